// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor
//   Downstream of the ALIF neuron. Turns the one-cycle `spike` pulse into two
//   measurements a host can read at leisure:
//     - rate : spikes counted over a window of WINDOW_LEN enabled cycles,
//              offered through a valid/ready handshake (sticky overflow when
//              an unconsumed result is overwritten);
//     - isi  : last inter-spike interval in cycles (saturating at 255).
//   Optional burst detection is compiled in with the macro
//   SPIKE_RATE_MONITOR_BURST_EN; without it `burst` is tied low.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   measurement enable; low returns to IDLE and clears counters
//   spike      in   spike pulse, sampled every cycle
//   rate       out  [7:0] spike count of last completed window (sat. 255)
//   rate_valid out  rate holds an unconsumed result
//   rate_ready in   consumer accepts rate when rate_valid & rate_ready
//   overflow   out  sticky: a result overwrote an unconsumed one
//   isi        out  [7:0] last inter-spike interval (sat. 255)
//   isi_valid  out  at least one interval measured
//   burst      out  one-cycle pulse when a new isi <= BURST_ISI (optional)

module spike_rate_monitor #(
  parameter int WINDOW_LEN = 256,
  parameter int BURST_ISI  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       spike,
  output logic [7:0] rate,
  output logic       rate_valid,
  input  logic       rate_ready,
  output logic       overflow,
  output logic [7:0] isi,
  output logic       isi_valid,
  output logic       burst
);

  localparam int            CW       = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]    spk_cnt_q, spk_cnt_d;
  logic [7:0]    isi_cnt_q, isi_cnt_d;
  logic [7:0]    rate_q, rate_d;
  logic [7:0]    isi_q, isi_d;
  logic          rate_valid_q, rate_valid_d;
  logic          overflow_q, overflow_d;
  logic          isi_valid_q, isi_valid_d;

  logic          window_end;
  logic [7:0]    spk_cnt_inc;
  logic [7:0]    isi_cnt_inc;

  assign window_end  = enable && (win_cnt_q == WIN_LAST);
  // Saturating increments: the count includes the current cycle's spike.
  assign spk_cnt_inc = (spike && (spk_cnt_q != 8'hFF)) ? spk_cnt_q + 8'd1 : spk_cnt_q;
  assign isi_cnt_inc = (isi_cnt_q != 8'hFF) ? isi_cnt_q + 8'd1 : isi_cnt_q;

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    isi_cnt_d    = isi_cnt_q;
    rate_d       = rate_q;
    isi_d        = isi_q;
    rate_valid_d = rate_valid_q;
    overflow_d   = overflow_q;
    isi_valid_d  = isi_valid_q;

    // Handshake is independent of enable; a load below may re-assert valid.
    if (rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end

    if (!enable) begin
      state_d   = IDLE;
      win_cnt_d = '0;
      spk_cnt_d = '0;
      isi_cnt_d = '0;
    end else begin
      win_cnt_d = window_end ? '0 : win_cnt_q + CW'(1);

      if (window_end) begin
        rate_d       = spk_cnt_inc;
        rate_valid_d = 1'b1;
        spk_cnt_d    = '0;
        // Overwriting a result that is not being taken this very cycle.
        if (rate_valid_q && !rate_ready) begin
          overflow_d = 1'b1;
        end
      end else begin
        spk_cnt_d = spk_cnt_inc;
      end

      case (state_q)
        MEASURE: begin
          if (spike) begin
            isi_d       = isi_cnt_q;
            isi_valid_d = 1'b1;
            isi_cnt_d   = 8'd1;   // this spike is the new reference
          end else begin
            isi_cnt_d   = isi_cnt_inc;
          end
        end
        default: begin
          // IDLE/ARMED: the first spike only establishes the reference.
          if (spike) begin
            state_d   = MEASURE;
            isi_cnt_d = 8'd1;
          end else begin
            state_d   = ARMED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      isi_cnt_q    <= '0;
      rate_q       <= '0;
      isi_q        <= '0;
      rate_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      rate_q       <= rate_d;
      isi_q        <= isi_d;
      rate_valid_q <= rate_valid_d;
      overflow_q   <= overflow_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign overflow   = overflow_q;
  assign isi        = isi_q;
  assign isi_valid  = isi_valid_q;

`ifdef SPIKE_RATE_MONITOR_BURST_EN
  logic burst_q, burst_d;

  // Same condition that publishes a new isi, plus the short-interval test.
  always_comb begin
    burst_d = enable && spike && (state_q == MEASURE) && (int'(isi_cnt_q) <= BURST_ISI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= 1'b0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign burst = burst_q;
`else
  // BURST_ISI has no effect in this build; the constant term folds to 0.
  assign burst = (BURST_ISI < 0) && 1'b0;
`endif

endmodule
